// File: rtl/switch_allocator_pkg.sv
// Router-wide NoC parameters shared by the switch allocator and its arbiters.
package noc_params;

    localparam int PORT_NUM    = 5;
    localparam int VC_NUM      = 2;
    localparam int BUFFER_SIZE = 8;
    localparam int PORT_SIZE   = $clog2(PORT_NUM);
    localparam int VC_SIZE     = $clog2(VC_NUM);
    localparam int CREDIT_W    = $clog2(BUFFER_SIZE + 1);

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// The pointer moves past the winner only when update_i confirms the grant was used.
module round_robin_arbiter #(
    parameter int AGENTS_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AGENTS_NUM-1:0] requests_i,
    input  logic                  update_i,
    output logic [AGENTS_NUM-1:0] grants_o
);

    localparam int PTR_W = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] win_idx;
    logic             found;

    // First pass searches [ptr, N-1], second pass wraps to [0, ptr-1].
    always_comb begin
        grants_o = '0;
        win_idx  = '0;
        found    = 1'b0;
        for (int i = 0; i < AGENTS_NUM; i++) begin
            if (!found && requests_i[i] && (PTR_W'(i) >= ptr_q)) begin
                grants_o[i] = 1'b1;
                win_idx     = PTR_W'(i);
                found       = 1'b1;
            end
        end
        for (int i = 0; i < AGENTS_NUM; i++) begin
            if (!found && requests_i[i]) begin
                grants_o[i] = 1'b1;
                win_idx     = PTR_W'(i);
                found       = 1'b1;
            end
        end
    end

    // Kept apart from the grant logic: update_i is derived from grants_o.
    always_comb begin
        ptr_d = ptr_q;
        if (update_i && found) begin
            ptr_d = (win_idx == PTR_W'(AGENTS_NUM - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Credit-aware separable input-first switch allocator: per-input VC arbitration,
// then per-output port arbitration, with one credit counter per downstream VC.
module switch_allocator
    import noc_params::*;
(
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]             sa_request_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   down_vc_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]             credit_i,
    output logic [PORT_NUM-1:0][VC_NUM-1:0]             grant_o,
    output logic [PORT_NUM-1:0][PORT_SIZE-1:0]          xb_sel_o,
    output logic [PORT_NUM-1:0]                         valid_o,
    output logic [PORT_NUM-1:0][VC_SIZE-1:0]            out_vc_o
);

    logic [PORT_NUM-1:0][VC_NUM-1:0][CREDIT_W-1:0] credit_q;
    logic [PORT_NUM-1:0][VC_NUM-1:0][CREDIT_W-1:0] credit_d;

    logic [PORT_NUM-1:0][VC_NUM-1:0]    eligible;
    logic [PORT_NUM-1:0][VC_NUM-1:0]    s1_gnt;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] s1_port;
    logic [PORT_NUM-1:0]                s1_valid;
    logic [PORT_NUM-1:0]                s1_update;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  s2_req;   // [output][input]
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  s2_gnt;   // [output][input]
    logic [PORT_NUM-1:0]                s2_update;

    // Out-of-range port/VC codes match no counter and are never eligible.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                for (int o = 0; o < PORT_NUM; o++) begin
                    for (int d = 0; d < VC_NUM; d++) begin
                        if (sa_request_i[p][v] &&
                            out_port_i[p][v] == PORT_SIZE'(o) &&
                            down_vc_i[p][v] == VC_SIZE'(d) &&
                            credit_q[o][d] != '0) begin
                            eligible[p][v] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_in_arb
        round_robin_arbiter #(.AGENTS_NUM(VC_NUM)) u_in_arb (
            .clk        (clk),
            .rst        (rst),
            .requests_i (eligible[p]),
            .update_i   (s1_update[p]),
            .grants_o   (s1_gnt[p])
        );
    end

    always_comb begin
        s1_port  = '0;
        s1_valid = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            s1_valid[p] = |s1_gnt[p];
            for (int v = 0; v < VC_NUM; v++) begin
                if (s1_gnt[p][v]) begin
                    s1_port[p] = out_port_i[p][v];
                end
            end
        end
    end

    always_comb begin
        s2_req = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                s2_req[o][p] = s1_valid[p] && (s1_port[p] == PORT_SIZE'(o));
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_out_arb
        round_robin_arbiter #(.AGENTS_NUM(PORT_NUM)) u_out_arb (
            .clk        (clk),
            .rst        (rst),
            .requests_i (s2_req[o]),
            .update_i   (s2_update[o]),
            .grants_o   (s2_gnt[o])
        );
    end

    // Everything is held at zero while rst is high, so no grant and no pointer move.
    always_comb begin
        grant_o  = '0;
        xb_sel_o = '0;
        valid_o  = '0;
        out_vc_o = '0;
        if (!rst) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                for (int p = 0; p < PORT_NUM; p++) begin
                    if (s2_gnt[o][p]) begin
                        valid_o[o]  = 1'b1;
                        xb_sel_o[o] = PORT_SIZE'(p);
                        for (int v = 0; v < VC_NUM; v++) begin
                            if (s1_gnt[p][v]) begin
                                out_vc_o[o]   = down_vc_i[p][v];
                                grant_o[p][v] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        s1_update = '0;
        s2_update = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            s1_update[p] = |grant_o[p];
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            s2_update[o] = valid_o[o];
        end
    end

    // A grant and a returned credit on the same downstream VC cancel out.
    always_comb begin
        credit_d = credit_q;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int d = 0; d < VC_NUM; d++) begin
                if (rst) begin
                    credit_d[o][d] = CREDIT_W'(BUFFER_SIZE);
                end else if (credit_i[o][d] &&
                             !(valid_o[o] && out_vc_o[o] == VC_SIZE'(d))) begin
                    if (credit_q[o][d] != CREDIT_W'(BUFFER_SIZE)) begin
                        credit_d[o][d] = credit_q[o][d] + 1'b1;
                    end
                end else if (!credit_i[o][d] &&
                             valid_o[o] && out_vc_o[o] == VC_SIZE'(d)) begin
                    credit_d[o][d] = credit_q[o][d] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        credit_q <= credit_d;
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: expected outputs are queued as each cycle
// is driven and compared at the falling edge of that same cycle.
module tb_switch_allocator;
    import noc_params::*;

    localparam int G_W   = PORT_NUM * VC_NUM;
    localparam int X_W   = PORT_NUM * PORT_SIZE;
    localparam int O_W   = PORT_NUM * VC_SIZE;
    localparam int EXP_W = G_W + PORT_NUM + X_W + O_W;

    logic clk;
    logic rst;
    logic [PORT_NUM-1:0][VC_NUM-1:0]                sa;
    logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] op;
    logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   dv;
    logic [PORT_NUM-1:0][VC_NUM-1:0]                cr;
    logic [PORT_NUM-1:0][VC_NUM-1:0]                grant_o;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0]             xb_sel_o;
    logic [PORT_NUM-1:0]                            valid_o;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]               out_vc_o;

    logic [PORT_NUM-1:0][VC_NUM-1:0]    e_gnt;
    logic [PORT_NUM-1:0]                e_val;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] e_xb;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   e_ovc;

    logic [EXP_W-1:0] exp_q[$];
    int    n_checks;
    int    n_fail;
    string cur_test;

    switch_allocator dut (
        .clk          (clk),
        .rst          (rst),
        .sa_request_i (sa),
        .out_port_i   (op),
        .down_vc_i    (dv),
        .credit_i     (cr),
        .grant_o      (grant_o),
        .xb_sel_o     (xb_sel_o),
        .valid_o      (valid_o),
        .out_vc_o     (out_vc_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic begin_cycle();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        sa    = '0;
        op    = '0;
        dv    = '0;
        cr    = '0;
        e_gnt = '0;
        e_val = '0;
        e_xb  = '0;
        e_ovc = '0;
    endtask

    task automatic end_cycle();
        exp_q.push_back({e_gnt, e_val, e_xb, e_ovc});
    endtask

    task automatic req(input int p, input int v, input int o, input int d);
        sa[p][v] = 1'b1;
        op[p][v] = PORT_SIZE'(o);
        dv[p][v] = VC_SIZE'(d);
    endtask

    task automatic expect_win(input int p, input int v, input int o, input int d);
        e_gnt[p][v] = 1'b1;
        e_val[o]    = 1'b1;
        e_xb[o]     = PORT_SIZE'(p);
        e_ovc[o]    = VC_SIZE'(d);
    endtask

    task automatic reset_cycle();
        begin_cycle();
        rst = 1'b1;
        end_cycle();
    endtask

    task automatic idle_gap();
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    // scoreboard
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq({cur_test, "/grant"},  64'(grant_o),  64'(e[EXP_W-1 -: G_W]));
            check_eq({cur_test, "/valid"},  64'(valid_o),  64'(e[O_W+X_W +: PORT_NUM]));
            check_eq({cur_test, "/xb_sel"}, 64'(xb_sel_o), 64'(e[O_W +: X_W]));
            check_eq({cur_test, "/out_vc"}, 64'(out_vc_o), 64'(e[0 +: O_W]));
        end
    end

    int t2_p[3] = '{0, 2, 4};
    int t2_v[3] = '{0, 0, 1};
    int t2_d[3] = '{0, 1, 0};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        sa  = '0;
        op  = '0;
        dv  = '0;
        cr  = '0;

        // Reset: requests present while rst is high must produce nothing.
        cur_test = "reset";
        for (int k = 0; k < 2; k++) begin
            begin_cycle();
            rst = 1'b1;
            req(1, 0, 3, 1);
            req(4, 1, 0, 0);
            cr = '1;
            end_cycle();
        end
        begin_cycle();
        for (int o = 0; o < PORT_NUM; o++)
            for (int d = 0; d < VC_NUM; d++)
                check_eq($sformatf("reset/credit_%0d_%0d", o, d), 64'(dut.credit_q[o][d]), 64'(BUFFER_SIZE));
        end_cycle();

        // Single request: same-cycle grant, one credit consumed.
        cur_test = "single";
        begin_cycle();
        req(1, 0, 3, 1);
        expect_win(1, 0, 3, 1);
        end_cycle();
        begin_cycle();
        check_eq("single/credit_after_grant", 64'(dut.credit_q[3][1]), 64'(BUFFER_SIZE - 1));
        cr[3][1] = 1'b1;
        end_cycle();
        begin_cycle();
        check_eq("single/credit_returned", 64'(dut.credit_q[3][1]), 64'(BUFFER_SIZE));
        end_cycle();

        // Output contention: three inputs rotate on output 1.
        reset_cycle();
        idle_gap();
        cur_test = "out_contention";
        for (int k = 0; k < 6; k++) begin
            begin_cycle();
            for (int j = 0; j < 3; j++) req(t2_p[j], t2_v[j], 1, t2_d[j]);
            expect_win(t2_p[k % 3], t2_v[k % 3], 1, t2_d[k % 3]);
            cr[1][t2_d[k % 3]] = 1'b1;
            end_cycle();
        end
        begin_cycle();
        check_eq("out_contention/credit_1_0", 64'(dut.credit_q[1][0]), 64'(BUFFER_SIZE));
        check_eq("out_contention/credit_1_1", 64'(dut.credit_q[1][1]), 64'(BUFFER_SIZE));
        end_cycle();

        // Input contention: two VCs of input 2 alternate.
        reset_cycle();
        idle_gap();
        cur_test = "in_contention";
        for (int k = 0; k < 4; k++) begin
            begin_cycle();
            req(2, 0, 0, 0);
            req(2, 1, 4, 1);
            if (k % 2 == 0) expect_win(2, 0, 0, 0);
            else            expect_win(2, 1, 4, 1);
            end_cycle();
        end

        // Credit exhaustion on downstream VC [2][0].
        reset_cycle();
        idle_gap();
        cur_test = "exhaust";
        for (int k = 0; k < BUFFER_SIZE; k++) begin
            begin_cycle();
            req(3, 1, 2, 0);
            expect_win(3, 1, 2, 0);
            end_cycle();
        end
        begin_cycle();
        check_eq("exhaust/credit_zero", 64'(dut.credit_q[2][0]), 64'd0);
        req(3, 1, 2, 0);
        end_cycle();
        begin_cycle();
        req(3, 1, 2, 0);
        cr[2][0] = 1'b1;
        end_cycle();
        begin_cycle();
        req(3, 1, 2, 0);
        expect_win(3, 1, 2, 0);
        end_cycle();
        begin_cycle();
        req(3, 1, 2, 0);
        end_cycle();

        // Grant and credit in the same cycle leave the counter unchanged.
        reset_cycle();
        idle_gap();
        cur_test = "grant_and_credit";
        for (int k = 0; k < 12; k++) begin
            begin_cycle();
            req(1, 1, 0, 1);
            expect_win(1, 1, 0, 1);
            if (k >= 2) cr[0][1] = 1'b1;
            end_cycle();
        end
        begin_cycle();
        check_eq("grant_and_credit/credit_0_1", 64'(dut.credit_q[0][1]), 64'(BUFFER_SIZE - 2));
        end_cycle();

        // Reset in the middle of output contention.
        reset_cycle();
        idle_gap();
        cur_test = "mid_reset";
        for (int k = 0; k < 2; k++) begin
            begin_cycle();
            for (int j = 0; j < 3; j++) req(t2_p[j], t2_v[j], 1, t2_d[j]);
            expect_win(t2_p[k], t2_v[k], 1, t2_d[k]);
            end_cycle();
        end
        begin_cycle();
        rst = 1'b1;
        for (int j = 0; j < 3; j++) req(t2_p[j], t2_v[j], 1, t2_d[j]);
        cr[1][0] = 1'b1;
        end_cycle();
        for (int k = 0; k < 3; k++) begin
            begin_cycle();
            if (k == 0) begin
                check_eq("mid_reset/credit_1_0", 64'(dut.credit_q[1][0]), 64'(BUFFER_SIZE));
                check_eq("mid_reset/credit_1_1", 64'(dut.credit_q[1][1]), 64'(BUFFER_SIZE));
            end
            for (int j = 0; j < 3; j++) req(t2_p[j], t2_v[j], 1, t2_d[j]);
            expect_win(t2_p[k], t2_v[k], 1, t2_d[k]);
            end_cycle();
        end

        begin_cycle();
        end_cycle();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check_eq("drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
